// File: rtl/dut_txn_sequencer.sv
// dut_txn_sequencer: turns one (a,b) command into write A, write B, read Y on the delayed_dut register port.
// Latency: 6 cycles from cmd fire to rsp_valid with every rdy high; DUT rdy stalls add cycle for cycle.
// Backpressure: cmd_ready is low while a transaction is in flight; the response is held until rsp_ready.
//
// Ports: clk/reset_n (async active-low); cmd_valid/cmd_ready/cmd_a/cmd_b host command;
//        rsp_valid/rsp_ready/rsp_y/rsp_err response; busy, txn_count status;
//        dut_write_* and dut_read_* drive the delayed_dut register interface.
// Optional: define DUT_TXN_SEQUENCER_POLL_EN to poll the Y-not-empty status at YSTAT_ADDR before reading Y.
module dut_txn_sequencer #(
    parameter logic [2:0] A_ADDR     = 3'd4,
    parameter logic [2:0] B_ADDR     = 3'd5,
    parameter logic [2:0] Y_ADDR     = 3'd3,
    parameter logic [2:0] YSTAT_ADDR = 3'd2,
    parameter int         TIMEOUT    = 16,
    parameter int         CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_a,
    input  logic             cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_y,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count,
    output logic [2:0]       dut_write_address,
    output logic             dut_write_data,
    output logic             dut_write_en,
    input  logic             dut_write_rdy,
    output logic [2:0]       dut_read_address,
    output logic             dut_read_en,
    input  logic             dut_read_data,
    input  logic             dut_read_rdy
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

`ifdef DUT_TXN_SEQUENCER_POLL_EN
    typedef enum logic [2:0] {IDLE, WR_A, WR_B, POLL, RD_Y, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_Y, RESP} state_t;
    logic unused_ystat;
    assign unused_ystat = ^YSTAT_ADDR;
`endif

    state_t        state;
    logic          b_q;
    logic [TW-1:0] tmo_cnt;
    logic          wr_fire;
    logic          tmo_hit;

    assign wr_fire = dut_write_en & dut_write_rdy;
    // Last allowed stall cycle of a read; a fire in the same cycle takes priority.
    assign tmo_hit = (TIMEOUT != 0) && dut_read_en && !dut_read_rdy && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            b_q               <= 1'b0;
            tmo_cnt           <= '0;
            cmd_ready         <= 1'b1;
            rsp_valid         <= 1'b0;
            rsp_y             <= 1'b0;
            rsp_err           <= 1'b0;
            busy              <= 1'b0;
            txn_count         <= '0;
            dut_write_address <= 3'd0;
            dut_write_data    <= 1'b0;
            dut_write_en      <= 1'b0;
            dut_read_address  <= 3'd0;
            dut_read_en       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        // Operand A goes straight onto the write port; B is held for the second write.
                        b_q               <= cmd_b;
                        cmd_ready         <= 1'b0;
                        busy              <= 1'b1;
                        dut_write_en      <= 1'b1;
                        dut_write_address <= A_ADDR;
                        dut_write_data    <= cmd_a;
                        state             <= WR_A;
                    end
                end
                WR_A: begin
                    if (wr_fire) begin
                        dut_write_en <= 1'b0;
                        state        <= WR_B;
                    end
                end
                WR_B: begin
                    // First cycle here is the mandatory idle gap after the previous access.
                    if (!dut_write_en) begin
                        dut_write_en      <= 1'b1;
                        dut_write_address <= B_ADDR;
                        dut_write_data    <= b_q;
                    end else if (wr_fire) begin
                        dut_write_en <= 1'b0;
                        tmo_cnt      <= '0;
`ifdef DUT_TXN_SEQUENCER_POLL_EN
                        state        <= POLL;
`else
                        state        <= RD_Y;
`endif
                    end
                end
`ifdef DUT_TXN_SEQUENCER_POLL_EN
                POLL: begin
                    // Counter is not cleared between status reads: it bounds the whole poll.
                    if (!dut_read_en) begin
                        dut_read_en      <= 1'b1;
                        dut_read_address <= YSTAT_ADDR;
                    end else if (dut_read_rdy) begin
                        dut_read_en <= 1'b0;
                        if (dut_read_data) begin
                            tmo_cnt <= '0;
                            state   <= RD_Y;
                        end
                    end else if (tmo_hit) begin
                        dut_read_en <= 1'b0;
                        rsp_y       <= 1'b0;
                        rsp_err     <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
`endif
                RD_Y: begin
                    if (!dut_read_en) begin
                        dut_read_en      <= 1'b1;
                        dut_read_address <= Y_ADDR;
                    end else if (dut_read_rdy) begin
                        dut_read_en <= 1'b0;
                        rsp_y       <= dut_read_data;
                        rsp_err     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (tmo_hit) begin
                        dut_read_en <= 1'b0;
                        rsp_y       <= 1'b0;
                        rsp_err     <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dut_txn_sequencer.sv
// tb_dut_txn_sequencer: directed bench with a behavioural delayed_dut (Y = A xor B) and a response scoreboard.
// Latency: n/a (bench).
// Backpressure: the bench stalls DUT write/read rdy and rsp_ready to exercise hold behaviour.
module tb_dut_txn_sequencer;
`ifdef DUT_TXN_SEQUENCER_POLL_EN
    localparam int POLL_EXTRA = 2;
    localparam int POLL_READS = 1;
`else
    localparam int POLL_EXTRA = 0;
    localparam int POLL_READS = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_a = 1'b0;
    logic       cmd_b = 1'b0;
    logic       rsp_ready = 1'b1;
    logic       dut_write_rdy = 1'b1;
    logic       dut_read_rdy = 1'b1;
    logic       dut_read_data;
    logic       cmd_ready, rsp_valid, rsp_y, rsp_err, busy;
    logic [7:0] txn_count;
    logic [2:0] dut_write_address, dut_read_address;
    logic       dut_write_data, dut_write_en, dut_read_en;

    dut_txn_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_err(rsp_err),
        .busy(busy), .txn_count(txn_count),
        .dut_write_address(dut_write_address), .dut_write_data(dut_write_data),
        .dut_write_en(dut_write_en), .dut_write_rdy(dut_write_rdy),
        .dut_read_address(dut_read_address), .dut_read_en(dut_read_en),
        .dut_read_data(dut_read_data), .dut_read_rdy(dut_read_rdy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int t_fire = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural register file: A at 4, B at 5, Y = A ^ B at 3, status at 2.
    logic reg_a = 1'b0;
    logic reg_b = 1'b0;
    int   stat_idx = 0;
    int   stat_base = 0;
    int   stat_n = 0;
    logic stat_vals [3];

    always @(posedge clk) begin
        if (dut_write_en && dut_write_rdy) begin
            if (dut_write_address == 3'd4) reg_a <= dut_write_data;
            if (dut_write_address == 3'd5) reg_b <= dut_write_data;
        end
        if (dut_read_en && dut_read_rdy && dut_read_address == 3'd2) stat_idx <= stat_idx + 1;
    end

    always_comb begin
        dut_read_data = 1'b0;
        if (dut_read_address == 3'd3) dut_read_data = reg_a ^ reg_b;
        else if (dut_read_address == 3'd2) begin
            if (stat_idx - stat_base < stat_n) dut_read_data = stat_vals[stat_idx - stat_base];
            else dut_read_data = 1'b1;
        end
    end

    // Access log entries: {is_read, address, data}.
    logic [4:0] log_q [$];
    always @(negedge clk) begin
        if (reset_n && dut_write_en && dut_write_rdy) log_q.push_back({1'b0, dut_write_address, dut_write_data});
        if (reset_n && dut_read_en && dut_read_rdy) log_q.push_back({1'b1, dut_read_address, dut_read_data});
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Scoreboard: expected {y, err} pushed at issue, compared on every response fire.
    logic [1:0] sb_q [$];
    logic [1:0] mon_exp;
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) check("rsp_unexpected", sb_q.size(), 1);
            else begin
                mon_exp = sb_q.pop_front();
                check("rsp_y", int'(rsp_y), int'(mon_exp[1]));
                check("rsp_err", int'(rsp_err), int'(mon_exp[0]));
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic a, input logic b, input logic y, input logic err, input bit push);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            step;
            n++;
        end
        if (!cmd_ready) check("cmd_ready_wait", int'(cmd_ready), 1);
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        if (push) sb_q.push_back({y, err});
        t_fire = cyc;
        step;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            step;
            n++;
        end
        if (!rsp_valid) check("rsp_wait", int'(rsp_valid), 1);
        lat = cyc - t_fire;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    int         lat;
    int         n_stat;
    int         n_y;
    logic [3:0] y_tab = 4'b0110;   // expected Y indexed by {a,b}: 00->0 01->1 10->1 11->0

    initial begin
        repeat (3) step;
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_y", int'(rsp_y), 0);
        check("rst_rsp_err", int'(rsp_err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_txn_count", int'(txn_count), 0);
        check("rst_wr_en", int'(dut_write_en), 0);
        check("rst_rd_en", int'(dut_read_en), 0);
        check("rst_addrs", int'({dut_write_address, dut_read_address}), 0);
        check("rst_wr_data", int'(dut_write_data), 0);
        reset_n = 1'b1;
        step;

        // Basic: a=1 b=0 -> Y=1, minimum latency.
        log_q.delete();
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("basic_busy", int'(busy), 1);
        wait_rsp(lat);
        check("basic_latency", lat, 6 + POLL_EXTRA);
        step;
        check("basic_count", int'(txn_count), 1);
        check("basic_log_size", log_q.size(), 3 + POLL_READS);
        if (log_q.size() == 3 + POLL_READS) begin
            check("basic_wr_a", int'(log_q[0]), int'(5'b0_100_1));
            check("basic_wr_b", int'(log_q[1]), int'(5'b0_101_0));
            check("basic_rd_y", int'(log_q[$]), int'(5'b1_011_1));
        end

        // Write backpressure on WR_A, then response backpressure.
        dut_write_rdy = 1'b0;
        rsp_ready = 1'b0;
        issue(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("bp_wr_en", int'(dut_write_en), 1);
            check("bp_wr_addr", int'(dut_write_address), 4);
            check("bp_wr_data", int'(dut_write_data), 0);
            step;
        end
        dut_write_rdy = 1'b1;
        wait_rsp(lat);
        check("bp_latency", lat, 9 + POLL_EXTRA);
        for (int i = 0; i < 4; i++) begin
            check("bp_rsp_valid", int'(rsp_valid), 1);
            check("bp_rsp_y", int'(rsp_y), 1);
            check("bp_cmd_ready", int'(cmd_ready), 0);
            step;
        end
        rsp_ready = 1'b1;
        step;
        check("bp_count", int'(txn_count), 2);

        // Read timeout, then a normal transaction.
        dut_read_rdy = 1'b0;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_rsp(lat);
        check("tmo_latency", lat, 21);
        step;
        dut_read_rdy = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_rsp(lat);
        check("after_tmo_latency", lat, 6 + POLL_EXTRA);
        step;
        check("after_tmo_count", int'(txn_count), 4);

        // Reset while the B write is being presented.
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step;
        step;
        check("mid_wr_addr", int'(dut_write_address), 5);
        check("mid_wr_en_before", int'(dut_write_en), 1);
        reset_n = 1'b0;
        #1;
        check("mid_wr_en", int'(dut_write_en), 0);
        check("mid_busy", int'(busy), 0);
        step;
        step;
        reset_n = 1'b1;
        step;
        check("mid_cmd_ready", int'(cmd_ready), 1);
        check("mid_count", int'(txn_count), 0);

        // 256 back-to-back transactions across all operand combinations.
        for (int i = 0; i < 256; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            issue(ab[1], ab[0], y_tab[ab], 1'b0, 1'b1);
            wait_rsp(lat);
            step;
            if (i == 127) check("wrap_mid_count", int'(txn_count), 128);
        end
        check("wrap_count", int'(txn_count), 0);

`ifdef DUT_TXN_SEQUENCER_POLL_EN
        // Status reads return 0,0,1 before Y is read.
        stat_base = stat_idx;
        stat_vals[0] = 1'b0;
        stat_vals[1] = 1'b0;
        stat_vals[2] = 1'b1;
        stat_n = 3;
        log_q.delete();
        issue(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_rsp(lat);
        step;
        n_stat = 0;
        n_y = 0;
        foreach (log_q[k]) begin
            if (log_q[k][4] && log_q[k][3:1] == 3'd2) n_stat++;
            if (log_q[k][4] && log_q[k][3:1] == 3'd3) n_y++;
        end
        check("poll_stat_reads", n_stat, 3);
        check("poll_y_reads", n_y, 1);
        if (log_q.size() > 0) check("poll_last_is_y", int'(log_q[$][3:1]), 3);
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
